// File: rtl/pipelined_multiplier_param_if.sv
// Purpose : operand/result handshake bundle for pipelined_multiplier_param.
// Latency : n/a (wires only).
// Backpressure: OUT_READY low stalls the whole pipe; IN_READY reflects that stall.
// Ports   : IN_VALID/IN_READY/INPUT_A/INPUT_B/SIGNED_MODE form the operation
//           channel, RES/OUT_VALID/OUT_READY the product channel.
//           master = producer/consumer side, slave = multiplier side.
interface pipelined_multiplier_param_if #(
  parameter int W = 8
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [W-1:0]   INPUT_A;
  logic [W-1:0]   INPUT_B;
  logic           SIGNED_MODE;
  logic [2*W-1:0] RES;
  logic           OUT_VALID;
  logic           OUT_READY;

  modport master (
    output IN_VALID, INPUT_A, INPUT_B, SIGNED_MODE, OUT_READY,
    input  IN_READY, RES, OUT_VALID
  );

  modport slave (
    input  IN_VALID, INPUT_A, INPUT_B, SIGNED_MODE, OUT_READY,
    output IN_READY, RES, OUT_VALID
  );
endinterface

// File: rtl/pipelined_multiplier_param.sv
// Purpose : parametrised W x W signed/unsigned multiplier, product 2W bits.
// Latency : accept at edge n -> RES/OUT_VALID after edge n+STAGES-1; 1 op/cycle.
// Backpressure: OUT_VALID & ~OUT_READY freezes every stage; IN_READY = ~stall.
// Ports   : clk, rst (async, active high), bus (slave modport of
//           pipelined_multiplier_param_if: operation in, product out).
module pipelined_multiplier_param #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input logic                         clk,
  input logic                         rst,
  pipelined_multiplier_param_if.slave bus
);

  // NG adder stages follow the capture stage; each consumes G bits of B.
  localparam int NG = STAGES - 1;
  localparam int G  = (W + NG - 1) / NG;
  localparam int PW = 2 * W;

  logic [STAGES-1:0] vld;          // vld[k] = stage k holds a live operation
  logic [PW-1:0]     a_q   [NG];   // extended multiplicand, stages 0..NG-1
  logic [W-1:0]      b_q   [NG];
  logic [NG-1:0]     m_q;
  logic [PW-1:0]     acc_q [NG];   // acc_q[i] is the running sum of stage i+1
  logic              stall;

  // Sum of the partial products of B's bit group g. A arrives already
  // extended to 2W bits according to the mode. In signed mode B's MSB
  // carries weight -2^(W-1), so its partial product is subtracted.
  function automatic logic [PW-1:0] group_sum(input int g,
                                              input logic [PW-1:0] a,
                                              input logic [W-1:0]  b,
                                              input logic          sm);
    logic [PW-1:0] s;
    s = '0;
    for (int j = 0; j < W; j++) begin
      if ((j / G) == g && b[j]) begin
        if (sm && j == W - 1) s = s - (a << j);
        else                  s = s + (a << j);
      end
    end
    return s;
  endfunction

  assign stall         = vld[STAGES-1] & ~bus.OUT_READY;
  assign bus.IN_READY  = ~stall;
  assign bus.OUT_VALID = vld[STAGES-1];
  assign bus.RES       = acc_q[NG-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      m_q <= '0;
      for (int i = 0; i < NG; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else if (!stall) begin
      // Whole-pipe advance; a bubble simply shifts through with vld=0.
      vld    <= {vld[STAGES-2:0], bus.IN_VALID};
      a_q[0] <= bus.SIGNED_MODE ? {{W{bus.INPUT_A[W-1]}}, bus.INPUT_A}
                                : {{W{1'b0}}, bus.INPUT_A};
      b_q[0] <= bus.INPUT_B;
      m_q[0] <= bus.SIGNED_MODE;
      for (int i = 1; i < NG; i++) begin
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
        m_q[i] <= m_q[i-1];
      end
      acc_q[0] <= group_sum(0, a_q[0], b_q[0], m_q[0]);
      for (int i = 1; i < NG; i++) begin
        acc_q[i] <= acc_q[i-1] + group_sum(i, a_q[i], b_q[i], m_q[i]);
      end
    end
  end

endmodule
